logic_unit_pipe: RTL and testbench
==================================

Name: logic_unit_pipe

Overview:
- Parametrised successor to the registered single-bit gate. It is a WIDTH-bit bitwise logic unit with a selectable operation and a configurable pipeline depth.
- Each stage uses a valid/ready handshake, so the unit can sit between streaming producers and consumers and absorb backpressure.
- Used as the standard registered logic primitive in the datapath and as the cocotb handshake training block.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1)
- STAGES, 2, number of pipeline register stages (>=1); latency without backpressure equals STAGES

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream presents a, b, op
- in_ready  output  1  unit accepts the upstream beat this cycle
- op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NAND
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  y holds a valid result
- out_ready  input  1  downstream accepts y this cycle
- y  output  WIDTH  registered result

Behaviour:
- Reset: async assert clears all stage valid bits and all stage data registers to 0. While rst is high: out_valid=0, y=0, in_ready=0. in_ready returns to 1 on the first cycle after deassertion.
- Result computation: the result is computed combinationally from a, b, op and captured into stage 0. Later stages only carry data and are never recomputed.
- Stage ready rule: ready[i] = !valid[i] || ready[i+1], with ready[STAGES] = out_ready.
  - in_ready = ready[0]. This is a combinational path from out_ready and is permitted.
- Input transfer: occurs on a clock edge where in_valid && in_ready.
- Stage i update when ready[i]=1:
  - valid[i] <= valid[i-1] (or in_valid for i=0).
  - data[i] <= data[i-1] (or the computed result for i=0), only when the incoming valid is 1.
  - Otherwise data holds its value; there are no gratuitous toggles.
- Stage hold: when ready[i]=0, stage i holds both valid and data.
- Output stability: y and out_valid are the last stage's registers. While out_valid && !out_ready, y must stay stable until accepted.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1, given no backpressure.
- Throughput and capacity:
  - Throughput is 1 beat/cycle when out_ready=1.
  - The pipeline holds at most STAGES beats. When all stages are valid and out_ready=0, in_ready=0.
- Simultaneous events: when full and out_ready=1, an output pop and an input push occur on the same edge with no bubble.
- Ordering: results leave in acceptance order, with no loss and no duplication.
- Reset mid-operation: all in-flight beats are discarded and no partial result is emitted.
- Operand semantics:
  - All operations are bitwise over WIDTH bits. NAND = ~(a & b), masked to WIDTH.
  - op is sampled only with a transferred beat.

Optional Feature:
- Macro: LOGIC_UNIT_TXN_COUNT_EN
- Defined:
  - Adds output port txn_count (16 bits), reset 0.
  - Increments by 1 on each edge with out_valid && out_ready.
  - Wraps 16'hFFFF -> 16'h0000.
- Undefined:
  - Port and counter are absent; all other behaviour is identical.

Decomposition:
- Package logic_unit_pkg:
  - typedef lu_op_t (2-bit enum: LU_AND=0, LU_OR=1, LU_XOR=2, LU_NAND=3)
  - localparam LU_TXN_CNT_W=16
- Sub-module lu_pipe_stage:
  - One valid/data register with the ready rule, parametrised by WIDTH.
  - Instantiated STAGES times in a generate loop.
  - Top level holds the op decode and the optional counter.

Test Plan:
- Reset: rst=1 mid-traffic for 2 cycles -> out_valid=0, y=0, in_ready=0; after release, in_ready=1 and no stale beat appears.
- Op sweep (WIDTH=8, STAGES=2, out_ready=1), a=8'hF0, b=8'hCC, op=0..3 on consecutive cycles -> y=8'hC0, 8'hFC, 8'h3C, 8'h3F. Each y appears 2 cycles after acceptance.
- Backpressure: out_ready=0, push 3 beats -> the first 2 are accepted, then in_ready=0. y holds its first result, stable for 10 cycles. out_ready=1 -> results drain in order.
- Full-throughput: out_ready=1, push 100 random beats back-to-back -> 100 results, in order, matching the model, with no bubble after the first STAGES-cycle latency.
- Random valid/ready toggling, 1000 beats with STAGES=1 and STAGES=4 -> scoreboard match and no drop/duplicate.
- LOGIC_UNIT_TXN_COUNT_EN: preload via 65537 transfers -> txn_count=1 (wrapped). Without the macro the build has no txn_count port.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared types and constants for the pipelined bitwise logic unit.
package logic_unit_pkg;

  typedef enum logic [1:0] {
    LU_AND  = 2'd0,
    LU_OR   = 2'd1,
    LU_XOR  = 2'd2,
    LU_NAND = 2'd3
  } lu_op_t;

  localparam int unsigned LU_TXN_CNT_W = 16;

endpackage

// File: rtl/lu_pipe_stage.sv
// One valid/data pipeline register with an elastic ready: it can take a new beat
// when empty or when its current beat is leaving downstream this cycle.
module lu_pipe_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  assign o_ready = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      // Data only moves with a valid beat so idle stages do not toggle.
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// WIDTH-bit bitwise logic unit behind a STAGES-deep valid/ready pipeline.
// Define LOGIC_UNIT_TXN_COUNT_EN to add the 16-bit txn_count output.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef LOGIC_UNIT_TXN_COUNT_EN
  output logic [LU_TXN_CNT_W-1:0] txn_count,
`endif
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] w_result;
  logic             w_stg_valid [STAGES+1];
  logic [WIDTH-1:0] w_stg_data  [STAGES+1];
  logic             w_stg_ready [STAGES+1];

  always_comb begin
    w_result = '0;
    case (lu_op_t'(op))
      LU_AND:  w_result = a & b;
      LU_OR:   w_result = a | b;
      LU_XOR:  w_result = a ^ b;
      LU_NAND: w_result = ~(a & b);
      default: w_result = '0;
    endcase
  end

  assign w_stg_valid[0]      = in_valid;
  assign w_stg_data[0]       = w_result;
  assign w_stg_ready[STAGES] = out_ready;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    lu_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_stg_valid[gi]),
      .i_data  (w_stg_data[gi]),
      .i_ready (w_stg_ready[gi+1]),
      .o_ready (w_stg_ready[gi]),
      .o_valid (w_stg_valid[gi+1]),
      .o_data  (w_stg_data[gi+1])
    );
  end

  // Refuse input while reset is held even though the stages read as empty.
  assign in_ready  = !rst && w_stg_ready[0];
  assign out_valid = w_stg_valid[STAGES];
  assign y         = w_stg_data[STAGES];

`ifdef LOGIC_UNIT_TXN_COUNT_EN
  logic [LU_TXN_CNT_W-1:0] r_txn_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_txn_count <= '0;
    end else if (out_valid && out_ready) begin
      r_txn_count <= r_txn_count + 1'b1;
    end
  end

  assign txn_count = r_txn_count;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: the driver tags each beat with its expected
// result, a negedge monitor queues accepted beats and checks them as they leave.
module tb_logic_unit_pipe;

  localparam int unsigned WIDTH  = 8;
  parameter  int unsigned STAGES = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [1:0]       op = 2'd0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] y;
`ifdef LOGIC_UNIT_TXN_COUNT_EN
  logic [15:0]      txn_count;
`endif

  logic [WIDTH-1:0] drv_exp = '0;
  logic [WIDTH-1:0] exp_q [$];
  int               t_q [$];
  int               n_cmp = 0;
  int               n_fail = 0;
  int               cyc = 0;
  bit               lat_chk = 1'b0;
  bit               done = 1'b0;

  logic [7:0] sw_a   [6] = '{8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hAA, 8'h00};
  logic [7:0] sw_b   [6] = '{8'hCC, 8'hCC, 8'hCC, 8'hCC, 8'h0F, 8'h00};
  logic [1:0] sw_op  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3};
  logic [7:0] sw_exp [6] = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'hA5, 8'hFF};

  logic_unit_pipe #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef LOGIC_UNIT_TXN_COUNT_EN
    .txn_count (txn_count),
`endif
    .y         (y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [7:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                       input logic [1:0] mop);
    case (mop)
      2'd0:    return ma & mb;
      2'd1:    return ma | mb;
      2'd2:    return ma ^ mb;
      default: return ~(ma & mb);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: everything is stable at the negedge and transfers on the next posedge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      t_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", {24'h0, y}, 32'hDEAD);
        end else begin
          check("y_result", {24'h0, y}, {24'h0, exp_q.pop_front()});
          if (lat_chk) check("latency", cyc - t_q.pop_front(), STAGES);
          else void'(t_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(drv_exp);
        t_q.push_back(cyc);
      end
    end
  end

  task automatic send(input logic [7:0] ia, input logic [7:0] ib, input logic [1:0] iop,
                      input logic [7:0] iexp);
    bit got = 1'b0;
    a = ia;
    b = ib;
    op = iop;
    drv_exp = iexp;
    in_valid = 1'b1;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
    end
    check("send_accepted", {31'h0, got}, 32'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    // Reset state
    repeat (2) begin
      @(negedge clk);
      check("rst_out_valid", {31'h0, out_valid}, 0);
      check("rst_y", {24'h0, y}, 0);
      check("rst_in_ready", {31'h0, in_ready}, 0);
`ifdef LOGIC_UNIT_TXN_COUNT_EN
      check("rst_txn_count", {16'h0, txn_count}, 0);
`endif
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'h0, in_ready}, 1);

    // Op sweep, no backpressure, latency checked per beat
    out_ready = 1'b1;
    lat_chk = 1'b1;
    for (int i = 0; i < 6; i++) send(sw_a[i], sw_b[i], sw_op[i], sw_exp[i]);
    drain();
    lat_chk = 1'b0;

    // Backpressure: fill, then a further beat must stall while y holds
    out_ready = 1'b0;
    for (int i = 0; i < int'(STAGES); i++) send(sw_a[i % 4], sw_b[i % 4], sw_op[i % 4],
                                                sw_exp[i % 4]);
    a = 8'hF0;
    b = 8'hCC;
    op = 2'd2;
    drv_exp = 8'h3C;
    in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("full_in_ready", {31'h0, in_ready}, 0);
      check("hold_out_valid", {31'h0, out_valid}, 1);
      check("hold_y", {24'h0, y}, 32'hC0);
    end
    out_ready = 1'b1;
    // Full and out_ready: push and pop share the same edge
    @(negedge clk);
    check("full_pop_push_ready", {31'h0, in_ready}, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

    // Back-to-back random burst; fixed latency means no bubbles
    lat_chk = 1'b1;
    for (int i = 0; i < 100; i++) begin
      logic [7:0] ra, rb;
      logic [1:0] ro;
      ra = 8'($urandom);
      rb = 8'($urandom);
      ro = 2'($urandom_range(0, 3));
      send(ra, rb, ro, model(ra, rb, ro));
    end
    drain();
    lat_chk = 1'b0;

    // Random valid gaps and random out_ready
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [7:0] ra, rb;
          logic [1:0] ro;
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          ra = 8'($urandom);
          rb = 8'($urandom);
          ro = 2'($urandom_range(0, 3));
          send(ra, rb, ro, model(ra, rb, ro));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-traffic discards in-flight beats
    out_ready = 1'b0;
    send(8'h12, 8'h34, 2'd1, 8'h36);
    send(8'h12, 8'h34, 2'd0, 8'h10);
    @(negedge clk);
    #2;
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("midrst_out_valid", {31'h0, out_valid}, 0);
      check("midrst_y", {24'h0, y}, 0);
      check("midrst_in_ready", {31'h0, in_ready}, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_release_in_ready", {31'h0, in_ready}, 1);
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_no_stale", {31'h0, out_valid}, 0);

`ifdef LOGIC_UNIT_TXN_COUNT_EN
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 65537; i++) send(8'h5A, 8'hFF, 2'd2, 8'hA5);
    drain();
    check("txn_count_wrap", {16'h0, txn_count}, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
